// File: rtl/axi_burst_addr_gen_if.sv
// Command/beat bundle for the burst address generator.
// slave: generator side; master: command source / beat sink.
interface axi_burst_addr_gen_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [ADDR_WIDTH-1:0] cmd_addr_i;
   logic [7:0]            cmd_len_i;
   logic [2:0]            cmd_size_i;
   logic [1:0]            cmd_burst_i;
   logic                  beat_valid_o;
   logic                  beat_ready_i;
   logic [ADDR_WIDTH-1:0] beat_addr_o;
   logic [STRB_WIDTH-1:0] beat_strb_o;
   logic [7:0]            beat_idx_o;
   logic                  beat_last_o;
   logic                  err_valid_o;
   logic [2:0]            err_code_o;
   logic                  busy_o;

   modport slave (
      input  cmd_valid_i, cmd_addr_i, cmd_len_i,
      input  cmd_size_i, cmd_burst_i, beat_ready_i,
      output cmd_ready_o, beat_valid_o, beat_addr_o,
      output beat_strb_o, beat_idx_o, beat_last_o,
      output err_valid_o, err_code_o, busy_o
   );

   modport master (
      output cmd_valid_i, cmd_addr_i, cmd_len_i,
      output cmd_size_i, cmd_burst_i, beat_ready_i,
      input  cmd_ready_o, beat_valid_o, beat_addr_o,
      input  beat_strb_o, beat_idx_o, beat_last_o,
      input  err_valid_o, err_code_o, busy_o
   );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address generator: one AW/AR command in, per-beat
// addr/strb/idx/last out (FIXED, INCR, WRAP), illegal commands flagged.
// Ports: aclk, aresetn (async, active-low), bus (slave modport):
//   cmd_* handshake in, beat_* handshake out, err_valid_o/err_code_o, busy_o.
module axi_burst_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input logic aclk,
   input logic aresetn,
   axi_burst_addr_gen_if.slave bus
);

   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_INCR  = 2'b01;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] B_RSVD  = 2'b11;

   // Wide enough that the last-byte sum of a 256 x 128B burst never overflows.
   localparam int XW = ADDR_WIDTH + 16;
   localparam int PW = XW - 12;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef enum logic [1:0] {IDLE, BURST, ERR} state_t;

   state_t state_q, state_d;

   addr_t      addr_q;
   addr_t      wrap_lo_q;
   addr_t      wrap_hi_q;
   logic [7:0] len_q;
   logic [7:0] idx_q;
   logic [2:0] size_q;
   logic [1:0] burst_q;
   logic [2:0] err_q;

   logic cmd_ready;
   logic beat_valid;
   logic err_valid;
   logic beat_last;
   logic cmd_fire;
   logic beat_fire;

   // Command-side decode: legality and wrap window.
   addr_t          c_bytes;
   addr_t          c_aligned;
   addr_t          c_total;
   addr_t          c_bound;
   logic [XW-1:0]  c_last;
   logic [2:0]     c_wrap_sh;
   logic           c_wrap_len_ok;
   logic [2:0]     c_err;

   always_comb begin
      c_bytes   = addr_t'(1) << bus.cmd_size_i;
      c_aligned = bus.cmd_addr_i & ~(c_bytes - addr_t'(1));
      c_last    = XW'(c_aligned)
                + (XW'({1'b0, bus.cmd_len_i} + 9'd1) << bus.cmd_size_i)
                - XW'(1);
      c_wrap_len_ok = (bus.cmd_len_i == 8'd1) || (bus.cmd_len_i == 8'd3)
                   || (bus.cmd_len_i == 8'd7) || (bus.cmd_len_i == 8'd15);
      if (bus.cmd_len_i[3])      c_wrap_sh = 3'd4;
      else if (bus.cmd_len_i[2]) c_wrap_sh = 3'd3;
      else if (bus.cmd_len_i[1]) c_wrap_sh = 3'd2;
      else                       c_wrap_sh = 3'd1;
      c_total = c_bytes << c_wrap_sh;
      c_bound = bus.cmd_addr_i & ~(c_total - addr_t'(1));

      // Lowest-numbered failing rule wins.
      c_err = 3'd0;
      if ((32'd1 << bus.cmd_size_i) > 32'(STRB_WIDTH))
         c_err = 3'd1;
      else if (bus.cmd_burst_i == B_WRAP && !c_wrap_len_ok)
         c_err = 3'd2;
      else if (bus.cmd_burst_i == B_WRAP
               && (bus.cmd_addr_i & (c_bytes - addr_t'(1))) != '0)
         c_err = 3'd3;
      else if (bus.cmd_burst_i == B_RSVD)
         c_err = 3'd4;
      else if (bus.cmd_burst_i == B_INCR
               && c_last[XW-1:12] != PW'(bus.cmd_addr_i[ADDR_WIDTH-1:12]))
         c_err = 3'd5;
      else if (bus.cmd_burst_i == B_FIXED && bus.cmd_len_i > 8'd15)
         c_err = 3'd6;
   end

   // Beat-side arithmetic from the latched burst.
   addr_t q_bytes;
   addr_t q_lin;
   addr_t next_addr;
   addr_t lane_mask;
   addr_t lo;
   addr_t hi;
   logic [STRB_WIDTH-1:0] strb;

   always_comb begin
      q_bytes   = addr_t'(1) << size_q;
      // Aligning first makes an unaligned beat 0 step to the next boundary.
      q_lin     = (addr_q & ~(q_bytes - addr_t'(1))) + q_bytes;
      next_addr = q_lin;
      if (burst_q == B_FIXED)
         next_addr = addr_q;
      else if (burst_q == B_WRAP && q_lin == wrap_hi_q)
         next_addr = wrap_lo_q;

      lane_mask = addr_t'(STRB_WIDTH - 1);
      lo = addr_q & lane_mask;
      hi = (addr_q & ~(q_bytes - addr_t'(1)) & lane_mask)
         + q_bytes - addr_t'(1);
      strb = '0;
      for (int i = 0; i < STRB_WIDTH; i++)
         strb[i] = beat_valid && addr_t'(i) >= lo && addr_t'(i) <= hi;
   end

   assign beat_last = beat_valid && (idx_q == len_q);
   assign cmd_fire  = cmd_ready && bus.cmd_valid_i;
   assign beat_fire = beat_valid && bus.beat_ready_i;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      beat_valid = 1'b0;
      err_valid  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid_i)
               state_d = (c_err == 3'd0) ? BURST : ERR;
         end
         BURST: begin
            beat_valid = 1'b1;
            if (bus.beat_ready_i && idx_q == len_q)
               state_d = IDLE;
         end
         ERR: begin
            err_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         addr_q    <= '0;
         wrap_lo_q <= '0;
         wrap_hi_q <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         err_q     <= '0;
      end else if (cmd_fire) begin
         addr_q    <= bus.cmd_addr_i;
         wrap_lo_q <= c_bound;
         wrap_hi_q <= c_bound + c_total;
         len_q     <= bus.cmd_len_i;
         idx_q     <= '0;
         size_q    <= bus.cmd_size_i;
         burst_q   <= bus.cmd_burst_i;
         err_q     <= c_err;
      end else if (beat_fire) begin
         addr_q <= next_addr;
         idx_q  <= idx_q + 8'd1;
      end
   end

   assign bus.cmd_ready_o  = cmd_ready;
   assign bus.beat_valid_o = beat_valid;
   assign bus.beat_addr_o  = addr_q;
   assign bus.beat_strb_o  = strb;
   assign bus.beat_idx_o   = idx_q;
   assign bus.beat_last_o  = beat_last;
   assign bus.err_valid_o  = err_valid;
   assign bus.err_code_o   = err_valid ? err_q : 3'd0;
   assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Scoreboard bench for axi_burst_addr_gen: directed + random commands,
// expected beats/errors from an arithmetic reference model.
module tb_axi_burst_addr_gen;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;

   axi_burst_addr_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

   axi_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      bit        is_err;
      bit [2:0]  code;
      bit [31:0] addr;
      bit [7:0]  strb;
      int        idx;
      bit        last;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   bit   force_rdy = 1'b1;
   bit   force_val = 1'b1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic bit [2:0] ref_err(bit [31:0] a, int len, int size,
                                        int burst);
      longint bytes = longint'(1) << size;
      longint al;
      longint last;
      if (bytes > 8) return 3'd1;
      if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
         return 3'd2;
      if (burst == 2 && (a % bytes) != 0) return 3'd3;
      if (burst == 3) return 3'd4;
      if (burst == 1) begin
         al = longint'(a) - (a % bytes);
         last = al + (len + 1) * bytes - 1;
         if ((last >> 12) != (longint'(a) >> 12)) return 3'd5;
      end
      if (burst == 0 && len > 15) return 3'd6;
      return 3'd0;
   endfunction

   function automatic bit [31:0] ref_addr(bit [31:0] a, int len, int size,
                                          int burst, int n);
      longint bytes = longint'(1) << size;
      longint total = bytes * (len + 1);
      longint bnd;
      if (burst == 0 || n == 0) return a;
      if (burst == 1) return 32'(longint'(a) - (a % bytes) + n * bytes);
      bnd = longint'(a) - (a % total);
      return 32'(bnd + ((longint'(a) - bnd) + n * bytes) % total);
   endfunction

   function automatic bit [7:0] ref_strb(bit [31:0] a, int size);
      int bytes = 1 << size;
      int lo = int'(a % 8);
      int hi = int'((a - (a % bytes)) % 8) + bytes - 1;
      bit [7:0] s = '0;
      for (int i = 0; i < 8; i++) s[i] = (i >= lo && i <= hi);
      return s;
   endfunction

   function automatic bit ref_is_err(bit [31:0] a, int len, int size,
                                     int burst);
      return ref_err(a, len, size, burst) != 3'd0;
   endfunction

   task automatic push_expect(bit [31:0] a, int len, int size, int burst);
      exp_t e;
      bit [2:0] code = ref_err(a, len, size, burst);
      if (code != 0) begin
         e = '{is_err: 1'b1, code: code, addr: 0, strb: 0, idx: 0,
               last: 1'b0};
         sb.push_back(e);
      end else begin
         for (int n = 0; n <= len; n++) begin
            e.is_err = 1'b0;
            e.code   = 3'd0;
            e.addr   = ref_addr(a, len, size, burst, n);
            e.strb   = ref_strb(e.addr, size);
            e.idx    = n;
            e.last   = (n == len);
            sb.push_back(e);
         end
      end
   endtask

   // ---------------- beat_ready driver ----------------
   initial begin
      bus.beat_ready_i = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         bus.beat_ready_i = force_rdy ? force_val
                                      : ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- monitor ----------------
   initial begin
      bit        hold = 1'b0;
      bit        last_seen = 1'b0;
      bit [31:0] h_addr;
      bit [7:0]  h_strb;
      bit [7:0]  h_idx;
      bit        h_last;
      exp_t      e;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            hold = 1'b0;
            last_seen = 1'b0;
            continue;
         end
         if (last_seen) begin
            chk("ready_after_last", bus.cmd_ready_o, 1);
            last_seen = 1'b0;
         end
         if (hold) begin
            chk("stall_valid", bus.beat_valid_o, 1);
            chk("stall_addr", bus.beat_addr_o, h_addr);
            chk("stall_strb", bus.beat_strb_o, h_strb);
            chk("stall_idx", bus.beat_idx_o, h_idx);
            chk("stall_last", bus.beat_last_o, h_last);
         end
         hold = 1'b0;
         if (bus.beat_valid_o) begin
            if (!bus.beat_ready_i) begin
               hold   = 1'b1;
               h_addr = bus.beat_addr_o;
               h_strb = bus.beat_strb_o;
               h_idx  = bus.beat_idx_o;
               h_last = bus.beat_last_o;
            end else if (sb.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("beat_kind", 0, e.is_err);
               chk("beat_addr", bus.beat_addr_o, e.addr);
               chk("beat_strb", bus.beat_strb_o, e.strb);
               chk("beat_idx", bus.beat_idx_o, e.idx);
               chk("beat_last", bus.beat_last_o, e.last);
               if (bus.beat_last_o) last_seen = 1'b1;
            end
         end
         if (bus.err_valid_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_err", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("err_kind", 1, e.is_err);
               chk("err_code", bus.err_code_o, e.code);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(bit [31:0] a, int len, int size, int burst);
      @(posedge aclk);
      #1;
      bus.cmd_addr_i  = a;
      bus.cmd_len_i   = 8'(len);
      bus.cmd_size_i  = 3'(size);
      bus.cmd_burst_i = 2'(burst);
      bus.cmd_valid_i = 1'b1;
      @(posedge aclk);
      #1;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_addr_i  = $urandom;
      bus.cmd_len_i   = 8'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(sb.size() == 0 && bus.cmd_ready_o) && t < 3000) begin
         @(negedge aclk);
         t++;
      end
      chk("drain_timeout", t < 3000, 1);
   endtask

   task automatic run_cmd(bit [31:0] a, int len, int size, int burst);
      bit is_err = ref_is_err(a, len, size, burst);
      push_expect(a, len, size, burst);
      send(a, len, size, burst);
      @(negedge aclk);
      if (is_err) begin
         chk("err_pulse", bus.err_valid_o, 1);
         chk("err_no_beat", bus.beat_valid_o, 0);
         chk("err_busy", bus.busy_o, 1);
         @(negedge aclk);
         chk("err_one_cycle", bus.err_valid_o, 0);
         chk("ready_after_err", bus.cmd_ready_o, 1);
      end else begin
         chk("beat_latency", bus.beat_valid_o, 1);
         chk("burst_not_ready", bus.cmd_ready_o, 0);
      end
      wait_idle();
   endtask

   initial begin
      int t;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_addr_i  = '0;
      bus.cmd_len_i   = '0;
      bus.cmd_size_i  = '0;
      bus.cmd_burst_i = '0;
      #2;
      chk("rst_ready", bus.cmd_ready_o, 1);
      chk("rst_valid", bus.beat_valid_o, 0);
      chk("rst_strb", bus.beat_strb_o, 0);
      chk("rst_err", bus.err_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;

      // directed
      run_cmd(32'h1004, 3, 2, 1);
      run_cmd(32'h1038, 3, 3, 2);
      run_cmd(32'h2003, 1, 2, 1);
      run_cmd(32'h0FF0, 3, 3, 1);
      run_cmd(32'h0000, 0, 4, 1);
      run_cmd(32'h1000, 2, 2, 2);
      run_cmd(32'h1004, 3, 3, 2);
      run_cmd(32'h0000, 0, 2, 3);
      run_cmd(32'h0040, 16, 0, 0);
      run_cmd(32'h0FFC, 0, 2, 1);

      // FIXED with a 3-cycle stall at idx 1
      fork
         run_cmd(32'h40, 2, 1, 0);
         begin
            t = 0;
            do begin
               @(negedge aclk);
               t++;
            end while (!(bus.beat_valid_o && bus.beat_idx_o == 8'd0)
                       && t < 50);
            force_val = 1'b0;
            repeat (4) @(posedge aclk);
            force_val = 1'b1;
         end
      join

      // reset in the middle of a burst
      push_expect(32'h0, 7, 3, 1);
      send(32'h0, 7, 3, 1);
      t = 0;
      do begin
         @(negedge aclk);
         t++;
      end while (!(bus.beat_valid_o && bus.beat_idx_o == 8'd2) && t < 50);
      chk("reach_idx2", t < 50, 1);
      #2;
      aresetn = 1'b0;
      #1;
      chk("mid_rst_valid", bus.beat_valid_o, 0);
      chk("mid_rst_ready", bus.cmd_ready_o, 1);
      chk("mid_rst_idx", bus.beat_idx_o, 0);
      chk("mid_rst_addr", bus.beat_addr_o, 0);
      chk("mid_rst_busy", bus.busy_o, 0);
      sb.delete();
      @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      run_cmd(32'h0, 0, 3, 1);

      // random
      force_rdy = 1'b0;
      for (int k = 0; k < 60; k++) begin
         bit [31:0] a;
         int size, burst, len;
         size  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
         burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         a = {$urandom_range(0, 15), 12'h000} + 32'($urandom_range(0, 4095));
         if (burst == 2) begin
            case ($urandom_range(0, 4))
               0: len = 1;
               1: len = 3;
               2: len = 7;
               3: len = 15;
               default: len = $urandom_range(0, 16);
            endcase
            if ($urandom_range(0, 3) != 0)
               a = a & ~((32'd1 << size) - 32'd1);
         end else if (burst == 0) begin
            len = $urandom_range(0, 18);
         end else begin
            len = $urandom_range(0, 20);
         end
         run_cmd(a, len, size, burst);
      end

      repeat (3) @(negedge aclk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
